bcd_seven_segment_scanner: RTL and testbench
============================================

// Module: bcd_seven_segment_scanner
// PURPOSE
//   Downstream consumer of the 16-bit double-dabble converter. Captures its
//   20-bit packed BCD result, 5 digits, whenever FINISH is high.
//   Drives a 5-digit time-multiplexed common-anode 7-segment display:
//   one digit enabled at a time, rotated by a clock prescaler.
//   Blanks leading zeros and flags any non-decimal nibble.
// PARAMETERS
//   SCAN_DIV      50000  CLK cycles per digit slot; legal range 2..2^20-1
//   BLANK_LZ      1      1 = blank leading zeros; 0 = show all 5 digits
//   AN_ACT_LOW    1      1 = AN outputs active-low; 0 = active-high
//   SEG_ACT_LOW   1      1 = SEG outputs active-low; 0 = active-high
// PORTS
//   CLK     in   1   system clock; all logic on rising edge
//   RST     in   1   synchronous, active-high reset
//   BCD     in   20  packed BCD from converter; [3:0] = units ... [19:16] = 10^4
//   FINISH  in   1   converter-done level; BCD is valid while high
//   AN      out  5   digit enables; AN[i] drives digit i (0 = units)
//   SEG     out  7   segments {g,f,e,d,c,b,a}
//   ERR     out  1   high while any latched nibble is > 9
// BEHAVIOUR
//   - Reset (RST=1 at an edge):
//     - latch=0, pre=0, idx=0
//     - AN = all digits off; SEG = all segments off; ERR=0
//     - polarity of the off level follows the *_ACT_LOW parameters
//     - RST mid-scan or mid-capture aborts immediately; the latched value is lost.
//   - Capture: every edge with FINISH=1 and RST=0 loads latch <= BCD.
//     - FINISH=0 holds latch.
//     - Capture does not reset pre or idx; the scan phase is unaffected.
//   - Prescaler: pre counts 0..SCAN_DIV-1, then wraps to 0.
//     - On the edge where pre==SCAN_DIV-1, idx advances 0->1->2->3->4->0.
//     - Hence each digit is enabled for exactly SCAN_DIV cycles.
//   - Output register: AN, SEG and ERR are registered from the current idx and latch.
//     - Latency is 1 cycle from an idx or latch change to the pins.
//     - The first edge after RST falls shows digit 0.
//   - Exactly one AN bit is active, except when the selected digit is blanked;
//     then AN is all off and SEG is all off.
//   - Leading-zero blanking (BLANK_LZ=1):
//     - digit i (i>=1) is blanked iff latch nibbles i..4 are all zero.
//     - Digit 0 is never blanked, so value 0 displays "0".
//     - Blanking is computed from the latched value, never from live BCD.
//   - Decode (active-high form, {g..a}):
//     0=0111111 1=0000110 2=1011011 3=1001111 4=1100110
//     5=1101101 6=1111101 7=0000111 8=1111111 9=1101111
//   - Nibbles A..F display "-" (g only, 1000000) and are never treated as zero.
//   - ERR = OR over the 5 latched nibbles of (nibble > 9); registered like SEG.
//   - SEG is inverted when SEG_ACT_LOW=1; AN is inverted when AN_ACT_LOW=1.
//   - No combinational path from BCD or FINISH to any output.
// TESTING  (SCAN_DIV=4, BLANK_LZ=1, active-low)
//   1. RST high 3 cycles -> AN=11111, SEG=1111111, ERR=0.
//      Release -> next edge AN=11110, SEG=1000000 ("0").
//   2. BCD=20'h65535 with a 1-cycle FINISH pulse.
//      -> digits 0..4 show 5,3,5,5,6, each for 4 cycles, cycling 0..4 then wrapping to 0.
//   3. BCD=20'h00042 latched -> digit0 "2", digit1 "4".
//      Slots 2..4: AN=11111, SEG=1111111.
//      With BLANK_LZ=0, digits 2..4 show "0".
//   4. BCD=20'h0A001 latched -> ERR=1.
//      Digit 3 shows "-" (SEG=0111111); digits 1,2 show "0" (not blanked; A is nonzero).
//   5. Change BCD every cycle with FINISH=0 -> display and ERR unchanged.
//      Then FINISH=1 one cycle with BCD=20'h00007 -> one cycle later the current slot reflects 7 / blanking.
//   6. Assert RST mid-slot at idx=3 with latch=20'h12345 -> outputs off next edge.
//      After release, digit 0 shows "0" (latch cleared), scan restarts at idx 0.

Source files
------------

// File: rtl/bcd_seven_segment_scanner.sv
// Five-digit time-multiplexed 7-segment scanner for a packed BCD value.
// Captures BCD while FINISH is high and rotates one enabled digit per
// SCAN_DIV clocks. Leading zeros can be blanked, and any non-decimal
// nibble raises ERR. All outputs are registered.
module bcd_seven_segment_scanner #(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter bit          BLANK_LZ    = 1'b1,
  parameter bit          AN_ACT_LOW  = 1'b1,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [19:0] BCD,
  input  logic        FINISH,
  output logic [4:0]  AN,
  output logic [6:0]  SEG,
  output logic        ERR
);

  localparam logic [19:0] PRE_LAST = 20'(SCAN_DIV - 1);
  localparam logic [4:0]  AN_OFF   = AN_ACT_LOW  ? 5'b11111   : 5'b00000;
  localparam logic [6:0]  SEG_OFF  = SEG_ACT_LOW ? 7'b1111111 : 7'b0000000;

  logic [19:0] latch;
  logic [19:0] pre;
  logic [2:0]  idx;

  logic [3:0]  nib;
  logic [4:1]  lead_nz;
  logic        blank;
  logic [4:0]  an_hi;
  logic [6:0]  seg_hi;
  logic        err_c;

  // Hold the converter result; FINISH acts as a load enable.
  always_ff @(posedge CLK) begin
    if (RST)         latch <= '0;
    else if (FINISH) latch <= BCD;
  end

  // Prescaler rotates the active digit once every SCAN_DIV clocks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    end else begin
      pre <= pre + 20'd1;
    end
  end

  // Select the active nibble, decide blanking and decode to segments.
  always_comb begin
    nib     = 4'd0;
    blank   = 1'b0;
    an_hi   = 5'b00000;
    seg_hi  = 7'b0000000;

    // lead_nz[i] is set when any of nibbles i..4 is nonzero.
    lead_nz[4] = |latch[19:16];
    lead_nz[3] = lead_nz[4] | (|latch[15:12]);
    lead_nz[2] = lead_nz[3] | (|latch[11:8]);
    lead_nz[1] = lead_nz[2] | (|latch[7:4]);

    err_c = (latch[3:0]   > 4'd9) | (latch[7:4]   > 4'd9) |
            (latch[11:8]  > 4'd9) | (latch[15:12] > 4'd9) |
            (latch[19:16] > 4'd9);

    case (idx)
      3'd0: nib = latch[3:0];
      3'd1: begin nib = latch[7:4];   blank = BLANK_LZ && !lead_nz[1]; end
      3'd2: begin nib = latch[11:8];  blank = BLANK_LZ && !lead_nz[2]; end
      3'd3: begin nib = latch[15:12]; blank = BLANK_LZ && !lead_nz[3]; end
      3'd4: begin nib = latch[19:16]; blank = BLANK_LZ && !lead_nz[4]; end
      default: nib = 4'd0;
    endcase

    case (nib)
      4'd0:    seg_hi = 7'b0111111;
      4'd1:    seg_hi = 7'b0000110;
      4'd2:    seg_hi = 7'b1011011;
      4'd3:    seg_hi = 7'b1001111;
      4'd4:    seg_hi = 7'b1100110;
      4'd5:    seg_hi = 7'b1101101;
      4'd6:    seg_hi = 7'b1111101;
      4'd7:    seg_hi = 7'b0000111;
      4'd8:    seg_hi = 7'b1111111;
      4'd9:    seg_hi = 7'b1101111;
      default: seg_hi = 7'b1000000;
    endcase

    if (blank) begin
      seg_hi = 7'b0000000;
    end else begin
      an_hi = 5'b00001 << idx;
    end
  end

  // Register the pins so nothing combinational reaches the display.
  always_ff @(posedge CLK) begin
    if (RST) begin
      AN  <= AN_OFF;
      SEG <= SEG_OFF;
      ERR <= 1'b0;
    end else begin
      AN  <= an_hi  ^ {5{AN_ACT_LOW}};
      SEG <= seg_hi ^ {7{SEG_ACT_LOW}};
      ERR <= err_c;
    end
  end

endmodule

// File: tb/tb_bcd_seven_segment_scanner.sv
// Bench for bcd_seven_segment_scanner: two instances share stimulus, one
// blanking with active-low pins, one unblanked with active-high pins.
// A cycle model pushes expected pins per edge; tasks pop and compare.
module tb_bcd_seven_segment_scanner;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        finish;
  logic [19:0] bcd;
  logic [4:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        err_a, err_b;

  always #5 clk = ~clk;

  bcd_seven_segment_scanner #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1),
    .AN_ACT_LOW(1'b1), .SEG_ACT_LOW(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .BCD(bcd), .FINISH(finish),
    .AN(an_a), .SEG(seg_a), .ERR(err_a));

  bcd_seven_segment_scanner #(.SCAN_DIV(DIV), .BLANK_LZ(1'b0),
    .AN_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .BCD(bcd), .FINISH(finish),
    .AN(an_b), .SEG(seg_b), .ERR(err_b));

  typedef struct {
    logic [4:0] an_a; logic [6:0] seg_a; logic err_a;
    logic [4:0] an_b; logic [6:0] seg_b; logic err_b;
    int idx;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad   = 0;
  logic [19:0] m_latch;
  int          m_pre, m_idx;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] tbl [10];
    tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
            7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
    if (n > 4'd9) return 7'b1000000;
    return tbl[n];
  endfunction

  function automatic void model(input bit blz, input logic [19:0] l, input int i,
                                output logic [4:0] an, output logic [6:0] seg,
                                output logic err);
    logic [19:0] upper, t;
    upper = l >> (4 * i);
    err = 1'b0;
    for (int k = 0; k < 5; k++) begin
      t = l >> (4 * k);
      if (t[3:0] > 4'd9) err = 1'b1;
    end
    if (blz && i > 0 && upper == 20'd0) begin
      an = 5'b00000; seg = 7'b0000000;
    end else begin
      an = 5'(1 << i); seg = seg_of(upper[3:0]);
    end
  endfunction

  task automatic tick();
    exp_t x;
    logic [4:0] an; logic [6:0] seg; logic er;
    if (rst) begin
      x.an_a = 5'b11111; x.seg_a = 7'b1111111; x.err_a = 1'b0;
      x.an_b = 5'b00000; x.seg_b = 7'b0000000; x.err_b = 1'b0;
      x.idx = -1;
    end else begin
      model(1'b1, m_latch, m_idx, an, seg, er);
      x.an_a = ~an; x.seg_a = ~seg; x.err_a = er;
      model(1'b0, m_latch, m_idx, an, seg, er);
      x.an_b = an; x.seg_b = seg; x.err_b = er;
      x.idx = m_idx;
    end
    sb.push_back(x);
    if (rst) begin
      m_latch = '0; m_pre = 0; m_idx = 0;
    end else begin
      if (finish) m_latch = bcd;
      if (m_pre == DIV - 1) begin
        m_pre = 0; m_idx = (m_idx + 1) % 5;
      end else begin
        m_pre++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; finish = 1'b0; bcd = '0;
    repeat (3) begin
      tick(); e = sb.pop_front(); total++;
      if ({an_a, seg_a, err_a, an_b, seg_b, err_b} !==
          {e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b}) begin
        bad++;
        $display("FAIL reset_sb got a=%b/%b/%b b=%b/%b/%b want a=%b/%b/%b b=%b/%b/%b",
                 an_a, seg_a, err_a, an_b, seg_b, err_b,
                 e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b);
      end
    end
    total++;
    if (an_a !== 5'b11111 || seg_a !== 7'b1111111 || err_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_off got an=%b seg=%b err=%b want 11111/1111111/0", an_a, seg_a, err_a);
    end
    rst = 1'b0;
    tick(); e = sb.pop_front(); total++;
    if (an_a !== 5'b11110 || seg_a !== 7'b1000000 || an_b !== e.an_b || seg_b !== e.seg_b) begin
      bad++;
      $display("FAIL reset_release got an=%b seg=%b b=%b/%b want 11110/1000000 b=%b/%b",
               an_a, seg_a, an_b, seg_b, e.an_b, e.seg_b);
    end
  endtask

  task automatic test_scan();
    bcd = 20'h65535; finish = 1'b1;
    tick(); void'(sb.pop_front());
    finish = 1'b0; bcd = '0;
    repeat (2 * 5 * DIV) begin
      tick(); e = sb.pop_front(); total++;
      if ({an_a, seg_a, err_a, an_b, seg_b, err_b} !==
          {e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b}) begin
        bad++;
        $display("FAIL scan idx=%0d got a=%b/%b/%b b=%b/%b/%b want a=%b/%b/%b b=%b/%b/%b",
                 e.idx, an_a, seg_a, err_a, an_b, seg_b, err_b,
                 e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b);
      end
      if (e.idx == 4) begin
        total++;
        if (an_a !== 5'b01111 || seg_a !== 7'b0000010) begin
          bad++;
          $display("FAIL scan_digit4 got an=%b seg=%b want 01111/0000010", an_a, seg_a);
        end
      end
    end
  endtask

  task automatic test_blank();
    bcd = 20'h00042; finish = 1'b1;
    tick(); void'(sb.pop_front());
    finish = 1'b0;
    for (int k = 0; k < 5 * DIV + 2; k++) begin
      tick(); e = sb.pop_front(); total++;
      if ({an_a, seg_a, err_a, an_b, seg_b, err_b} !==
          {e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b}) begin
        bad++;
        $display("FAIL blank idx=%0d got a=%b/%b/%b b=%b/%b/%b want a=%b/%b/%b b=%b/%b/%b",
                 e.idx, an_a, seg_a, err_a, an_b, seg_b, err_b,
                 e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b);
      end
      if (e.idx >= 2) begin
        total++;
        if (an_a !== 5'b11111 || seg_a !== 7'b1111111 ||
            an_b !== 5'(1 << e.idx) || seg_b !== 7'b0111111) begin
          bad++;
          $display("FAIL blank_slot%0d got a=%b/%b b=%b/%b want 11111/1111111 b=onehot/0111111",
                   e.idx, an_a, seg_a, an_b, seg_b);
        end
      end
    end
  endtask

  task automatic test_err();
    bcd = 20'h0A001; finish = 1'b1;
    tick(); void'(sb.pop_front());
    finish = 1'b0;
    repeat (5 * DIV + 2) begin
      tick(); e = sb.pop_front(); total++;
      if ({an_a, seg_a, err_a, an_b, seg_b, err_b} !==
          {e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b}) begin
        bad++;
        $display("FAIL err idx=%0d got a=%b/%b/%b b=%b/%b/%b want a=%b/%b/%b b=%b/%b/%b",
                 e.idx, an_a, seg_a, err_a, an_b, seg_b, err_b,
                 e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b);
      end
      total++;
      if (err_a !== 1'b1 || err_b !== 1'b1 ||
          (e.idx == 3 && seg_a !== 7'b0111111) ||
          ((e.idx == 1 || e.idx == 2) && seg_a !== 7'b1000000)) begin
        bad++;
        $display("FAIL err_digit idx=%0d got err=%b/%b seg=%b", e.idx, err_a, err_b, seg_a);
      end
    end
  endtask

  task automatic test_hold();
    finish = 1'b0;
    repeat (15) begin
      bcd = 20'($urandom);
      tick(); e = sb.pop_front(); total++;
      if ({an_a, seg_a, err_a, an_b, seg_b, err_b} !==
          {e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b}) begin
        bad++;
        $display("FAIL hold idx=%0d got a=%b/%b/%b b=%b/%b/%b want a=%b/%b/%b b=%b/%b/%b",
                 e.idx, an_a, seg_a, err_a, an_b, seg_b, err_b,
                 e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b);
      end
    end
    bcd = 20'h00007; finish = 1'b1;
    tick(); void'(sb.pop_front());
    finish = 1'b0;
    repeat (12) begin
      bcd = 20'($urandom);
      tick(); e = sb.pop_front(); total++;
      if ({an_a, seg_a, err_a, an_b, seg_b, err_b} !==
          {e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b}) begin
        bad++;
        $display("FAIL hold_load idx=%0d got a=%b/%b/%b b=%b/%b/%b want a=%b/%b/%b b=%b/%b/%b",
                 e.idx, an_a, seg_a, err_a, an_b, seg_b, err_b,
                 e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b);
      end
    end
  endtask

  task automatic test_back_to_back();
    finish = 1'b1; bcd = 20'h89012;
    tick(); void'(sb.pop_front());
    bcd = 20'h34567;
    tick(); void'(sb.pop_front());
    finish = 1'b0;
    for (int k = 0; k < 5 * DIV + 40; k++) begin
      if (k >= 5 * DIV) begin
        finish = ($urandom_range(0, 3) == 0);
        bcd = 20'($urandom);
      end
      tick(); e = sb.pop_front(); total++;
      if ({an_a, seg_a, err_a, an_b, seg_b, err_b} !==
          {e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b}) begin
        bad++;
        $display("FAIL b2b idx=%0d got a=%b/%b/%b b=%b/%b/%b want a=%b/%b/%b b=%b/%b/%b",
                 e.idx, an_a, seg_a, err_a, an_b, seg_b, err_b,
                 e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b);
      end
    end
    finish = 1'b0;
  endtask

  task automatic test_mid_reset();
    int budget;
    bcd = 20'h12345; finish = 1'b1;
    tick(); void'(sb.pop_front());
    finish = 1'b0;
    budget = 0;
    while (!(m_idx == 3 && m_pre == 1) && budget < 60) begin
      tick(); e = sb.pop_front(); total++; budget++;
      if ({an_a, seg_a, err_a, an_b, seg_b, err_b} !==
          {e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b}) begin
        bad++;
        $display("FAIL midrst_pre idx=%0d got a=%b/%b/%b want a=%b/%b/%b",
                 e.idx, an_a, seg_a, err_a, e.an_a, e.seg_a, e.err_a);
      end
    end
    total++;
    if (budget >= 60) begin
      bad++;
      $display("FAIL midrst_wait got idx=%0d pre=%0d want idx=3 pre=1", m_idx, m_pre);
    end
    rst = 1'b1;
    tick(); void'(sb.pop_front()); total++;
    if (an_a !== 5'b11111 || seg_a !== 7'b1111111 || err_a !== 1'b0 ||
        an_b !== 5'b00000 || seg_b !== 7'b0000000) begin
      bad++;
      $display("FAIL midrst_off got a=%b/%b/%b b=%b/%b want 11111/1111111/0 b=00000/0000000",
               an_a, seg_a, err_a, an_b, seg_b);
    end
    rst = 1'b0;
    tick(); void'(sb.pop_front()); total++;
    if (an_a !== 5'b11110 || seg_a !== 7'b1000000 || an_b !== 5'b00001 || seg_b !== 7'b0111111) begin
      bad++;
      $display("FAIL midrst_release got a=%b/%b b=%b/%b want 11110/1000000 b=00001/0111111",
               an_a, seg_a, an_b, seg_b);
    end
    repeat (2 * DIV) begin
      tick(); e = sb.pop_front(); total++;
      if ({an_a, seg_a, err_a, an_b, seg_b, err_b} !==
          {e.an_a, e.seg_a, e.err_a, e.an_b, e.seg_b, e.err_b}) begin
        bad++;
        $display("FAIL midrst_post idx=%0d got a=%b/%b b=%b/%b want a=%b/%b b=%b/%b",
                 e.idx, an_a, seg_a, an_b, seg_b, e.an_a, e.seg_a, e.an_b, e.seg_b);
      end
    end
  endtask

  initial begin
    rst = 1'b1; finish = 1'b0; bcd = '0;
    m_latch = '0; m_pre = 0; m_idx = 0;
    test_reset();
    test_scan();
    test_blank();
    test_err();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
